// File: rtl/mmm_arbiter.sv
// Two-requester arbiter sequencing a shared Montgomery multiplier.
// Moore FSM: IDLE -> PRE -> RUN -> POST -> DONE -> IDLE.
module mmm_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       mmm_clr_n,
  output logic       ld_a,
  output logic       ld_r,
  output logic [1:0] done,
  output logic       busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    RUN,
    POST,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          win_q, win_d;
  logic          last_q, last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          // On a tie, the requester not served last time wins.
          win_d   = (req[0] & req[1]) ? ~last_q : req[1];
          last_d  = win_d;
          state_d = PRE;
        end
      end
      PRE: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q == CW'(WIDTH)) state_d = POST;
        else cnt_d = cnt_q + CW'(1);
      end
      POST: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    gnt       = 2'b00;
    sel       = 1'b0;
    if (busy) begin
      gnt = win_q ? 2'b10 : 2'b01;
      sel = win_q;
    end
    mmm_clr_n = (state_q == PRE) || (state_q == RUN)
             || (state_q == POST);
    ld_a      = (state_q == PRE);
    ld_r      = (state_q == POST);
    done      = (state_q == DONE) ? gnt : 2'b00;
  end

endmodule

// File: tb/tb_mmm_arbiter.sv
// Self-checking bench for mmm_arbiter: job-timeline model plus
// directed literal checks and randomized stimulus.
module tb_mmm_arbiter;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] gnt;
  logic       sel;
  logic       mmm_clr_n;
  logic       ld_a;
  logic       ld_r;
  logic [1:0] done;
  logic       busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Model: a job is a timeline of enabled cycles k = 1 .. W+4.
  bit m_busy = 0;
  int m_k    = 0;
  bit m_win  = 0;
  bit m_last = 1;

  mmm_arbiter #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .req(req),
    .gnt(gnt),
    .sel(sel),
    .mmm_clr_n(mmm_clr_n),
    .ld_a(ld_a),
    .ld_r(ld_r),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0;
      m_k    = 0;
      m_last = 1;
    end else if (ena) begin
      if (!m_busy) begin
        if (req != 2'b00) begin
          if (req == 2'b11) m_win = (m_last == 1) ? 0 : 1;
          else m_win = (req == 2'b10);
          m_last = m_win;
          m_busy = 1;
          m_k    = 1;
        end
      end else if (m_k == W + 4) begin
        m_busy = 0;
        m_k    = 0;
      end else begin
        m_k = m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] e_gnt, e_done;
    logic e_sel, e_clr, e_lda, e_ldr;
    if (chk_en) begin
      e_gnt  = m_busy ? (m_win ? 2'b10 : 2'b01) : 2'b00;
      e_sel  = m_busy ? m_win : 1'b0;
      e_clr  = m_busy && (m_k <= W + 3);
      e_lda  = m_busy && (m_k == 1);
      e_ldr  = m_busy && (m_k == W + 3);
      e_done = (m_busy && m_k == W + 4) ? e_gnt : 2'b00;
      checks++;
      if ({gnt, sel, mmm_clr_n, ld_a, ld_r, done, busy} !==
          {e_gnt, e_sel, e_clr, e_lda, e_ldr, e_done, m_busy}
          || !$onehot0(gnt) || ((done & ~gnt) != 2'b00)) begin
        errors++;
        $display("FAIL model t=%0t got gnt=%b sel=%b clr=%b lda=%b ldr=%b done=%b busy=%b exp gnt=%b sel=%b clr=%b lda=%b ldr=%b done=%b busy=%b",
                 $time, gnt, sel, mmm_clr_n, ld_a, ld_r, done, busy,
                 e_gnt, e_sel, e_clr, e_lda, e_ldr, e_done, m_busy);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    ena = 1;
    req = 2'b00;
    step();
    rst = 0;
  endtask

  initial begin
    int run_cnt;
    logic [1:0] dq[$];

    do_reset();
    chk_en = 1;
    lit("reset_outs", {gnt, sel, mmm_clr_n, ld_a, ld_r, done, busy}, 8'h00);

    // Single job, request dropped mid-RUN.
    req = 2'b01;
    run_cnt = 0;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 4) req = 2'b00;
      if (mmm_clr_n && !ld_a && !ld_r && gnt == 2'b01) run_cnt++;
      if (c == 1) lit("c1_lda_gnt", {ld_a, gnt}, 8'h05);
      if (c == 11) lit("c11_ldr", {ld_r, gnt}, 8'h05);
      if (c == 12) lit("c12_done", {done, gnt, mmm_clr_n}, 8'h0A);
      if (c == 13) lit("c13_idle", {gnt, busy}, 8'h00);
    end
    lit("run_cycles", 8'(run_cnt), 8'(W + 1));

    // Clock enable freeze for 5 cycles at counter 3.
    do_reset();
    req = 2'b01;
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c == 5) req = 2'b00;
      ena = (c >= 5 && c < 10) ? 1'b0 : 1'b1;
      lit($sformatf("frz_done_c%0d", c), {6'd0, done},
          (c == 17) ? 8'h01 : 8'h00);
    end
    ena = 1;

    // Tie held: strictly alternating grants.
    do_reset();
    req = 2'b11;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (done != 2'b00) dq.push_back(done);
    end
    req = 2'b00;
    lit("tie_n", 8'(dq.size()), 8'd3);
    if (dq.size() >= 3) begin
      lit("tie_1", {6'd0, dq[0]}, 8'h01);
      lit("tie_2", {6'd0, dq[1]}, 8'h02);
      lit("tie_3", {6'd0, dq[2]}, 8'h01);
    end

    // Reset during POST abandons the job.
    do_reset();
    req = 2'b10;
    for (int c = 1; c <= 11; c++) step();
    lit("post_ldr", {ld_r, gnt}, 8'h06);
    rst = 1;
    step();
    rst = 0;
    lit("rst_post", {gnt, busy, done}, 8'h00);
    req = 2'b11;
    step();
    lit("rst_tie", {6'd0, gnt}, 8'h01);
    req = 2'b00;
    for (int c = 0; c < 14; c++) step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 7) == 0) req[1] = ~req[1];
      ena = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0;
    ena = 1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmm_arbiter.md
MMM_ARBITER -- requirements
Module: mmm_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width of the shared Montgomery multiplier; one step per operand bit plus one.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port ena  input  1  clock enable; 0 freezes all state.
REQ-005 SHALL have port req  input  2  per-requester level request; held high until that requester's done pulse.
REQ-006 SHALL have port gnt  output  2  one-hot grant of the shared multiplier.
REQ-007 SHALL have port sel  output  1  operand/result mux select, equal to the granted requester index.
REQ-008 SHALL have port mmm_clr_n  output  1  multiplier enable: 0 clears the multiplier, 1 lets it run.
REQ-009 SHALL have port ld_a  output  1  one-cycle pulse loading operand A into the multiplier.
REQ-010 SHALL have port ld_r  output  1  one-cycle pulse capturing the multiplier result.
REQ-011 SHALL have port done  output  2  one-cycle completion pulse to the granted requester.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL implement the Moore FSM IDLE -> PRE -> RUN -> POST -> DONE -> IDLE; all outputs decode from registered state and pointer only.
REQ-014 IDLE: gnt=00, sel=0, mmm_clr_n=0, ld_a=0, ld_r=0, done=00; on any req bit high, go to PRE and register the winner.
REQ-015 Arbitration in IDLE: single request wins outright; on both requests high, grant the index not equal to last_gnt; last_gnt updates at the grant edge.
REQ-016 PRE (1 cycle): gnt/sel = winner, mmm_clr_n=1, ld_a=1, step counter cleared to 0.
REQ-017 RUN: mmm_clr_n=1, counter increments each enabled cycle; leave for POST when counter==WIDTH, i.e. exactly WIDTH+1 RUN cycles.
REQ-018 Counter SHALL be $clog2(WIDTH+1) bits wide and never wrap within an operation.
REQ-019 POST (1 cycle): mmm_clr_n=1, ld_r=1.
REQ-020 DONE (1 cycle): done[winner]=1, mmm_clr_n=0, gnt still held; next state IDLE unconditionally.
REQ-021 Latency: req sampled at edge 0 in IDLE -> PRE in cycle 1, RUN cycles 2..WIDTH+2, POST cycle WIDTH+3, DONE cycle WIDTH+4.
REQ-022 Back-to-back: at least one IDLE cycle between jobs; a request held through DONE is re-arbitrated in that IDLE cycle.
REQ-023 A req bit dropping mid-job SHALL NOT abort the job; the sequence completes and done still pulses.
REQ-024 A new request arriving from the non-granted requester while busy SHALL be ignored until IDLE.
REQ-025 With ena=0 the state, counter and last_gnt SHALL hold, and outputs SHALL stay at their current decoded values.
REQ-026 gnt SHALL never have both bits set; done SHALL only pulse on the bit matching gnt.

Reset
REQ-027 With rst=1 at a posedge, the next state is IDLE, counter=0 and last_gnt=1, so requester 0 wins the first tie; this applies regardless of ena.
REQ-028 Reset output values: gnt=00, sel=0, mmm_clr_n=0, ld_a=0, ld_r=0, done=00, busy=0.
REQ-029 rst asserted mid-job SHALL abandon the job with no done pulse; outputs reach reset values after that edge.

Verification
REQ-030 WIDTH=8, req=01 from IDLE -> gnt=01 cycles 1-12, ld_a in cycle 1, 9 RUN cycles, ld_r in cycle 11, done=01 in cycle 12.
REQ-031 After reset, req=11 held -> first grant 01, then 10 after one IDLE cycle, then 01; strictly alternating, each with done on the matching bit.
REQ-032 req=01 dropped in RUN cycle 4 -> sequence still reaches DONE with done=01 in cycle 12, then IDLE with gnt=00.
REQ-033 ena=0 for 5 cycles during RUN (counter=3) -> counter and outputs frozen; done slips exactly 5 cycles, to cycle 17.
REQ-034 rst pulsed in POST -> next cycle gnt=00, busy=0, no done pulse; the subsequent tie grants requester 0.
REQ-035 Every cycle of every test: gnt one-hot or zero, sel==index(gnt) when granted, ld_a/ld_r/done single-cycle.
